// File: rtl/sc_charge_supervisor_mc.sv
// sc_charge_supervisor_mc
// -----------------------------------------------------------------------------
// Multi-channel charge supervisor. Each charger channel runs its own
// charge-control FSM (IDLE/CHECK/WAIT/CHARGING/FAULT/LOCKOUT). All channels
// share one grid-state input and one ML instability forecast. A WAIT
// hysteresis timer delays resuming after instability, a retry counter locks a
// channel out after repeated faults, and a shared stagger arbiter spaces out
// charge starts to limit inrush on a weak grid.
//
// Ports:
//   clk                     clock
//   reset_n                 asynchronous active-low reset
//   grid_state[1:0]         00 NORMAL, 01 UNSTABLE, 10 CRITICAL, 11 invalid
//   ml_predict_instability  ML forecast of imminent instability
//   battery_connected[N]    per-channel battery presence
//   battery_full[N]         per-channel full indication
//   fault_clear             operator acknowledge (level, acts while high)
//   charge_enable[N]        channel i is CHARGING
//   fault_flag[N]           channel i is in FAULT or LOCKOUT
//   fault_code[4N]          channel i code in bits [4i+3:4i]
//   ch_state[3N]            channel i state in bits [3i+2:3i]
//   any_fault               OR of fault_flag
// -----------------------------------------------------------------------------
module sc_charge_supervisor_mc #(
    parameter int N_CH           = 4,
    parameter int WAIT_CYCLES    = 16,
    parameter int MAX_RETRY      = 3,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          grid_state,
    input  logic                ml_predict_instability,
    input  logic [N_CH-1:0]     battery_connected,
    input  logic [N_CH-1:0]     battery_full,
    input  logic                fault_clear,
    output logic [N_CH-1:0]     charge_enable,
    output logic [N_CH-1:0]     fault_flag,
    output logic [4*N_CH-1:0]   fault_code,
    output logic [3*N_CH-1:0]   ch_state,
    output logic                any_fault
);

    localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_CHARGING = 3'd3,
        ST_FAULT    = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_t;

    state_t          state_q  [N_CH];
    state_t          state_d  [N_CH];
    logic [3:0]      code_q   [N_CH];
    logic [3:0]      code_d   [N_CH];
    logic [3:0]      retry_q  [N_CH];
    logic [3:0]      retry_d  [N_CH];
    logic [WW-1:0]   stable_q [N_CH];
    logic [WW-1:0]   stable_d [N_CH];
    logic [SW-1:0]   stagger_q;
    logic [SW-1:0]   stagger_d;
    logic [N_CH-1:0] grant;

    logic [N_CH-1:0]   en_d;
    logic [N_CH-1:0]   flag_d;
    logic [4*N_CH-1:0] code_flat_d;
    logic [3*N_CH-1:0] st_flat_d;

    logic grid_normal, grid_unstable, grid_crit, grid_inv, clean;

    assign grid_normal   = (grid_state == 2'b00);
    assign grid_unstable = (grid_state == 2'b01);
    assign grid_crit     = (grid_state == 2'b10);
    assign grid_inv      = (grid_state == 2'b11);
    assign clean         = grid_normal && !ml_predict_instability;

    // Stagger arbiter: while the shared spacing counter is at zero, grant the
    // lowest-index channel sitting in CHECK on a clean grid. Only one grant per
    // cycle; a grant reloads the counter so the next start is held off.
    always_comb begin
        logic found;
        found     = 1'b0;
        grant     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && state_q[i] == ST_CHECK && clean && stagger_q == '0) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (found)
            stagger_d = SW'(STAGGER_CYCLES - 1);
        else if (stagger_q != '0)
            stagger_d = stagger_q - 1'b1;
        else
            stagger_d = '0;
    end

    // Per-channel next-state logic. Rules are checked in priority order; any
    // fault entry goes through a common path that bumps the retry counter and
    // diverts to LOCKOUT once the retry budget is used up. The stable counter
    // only runs in WAIT and is zero everywhere else.
    always_comb begin
        logic       fault_hit;
        logic [3:0] fault_kind;
        logic [3:0] retry_inc;
        fault_hit   = 1'b0;
        fault_kind  = 4'd0;
        retry_inc   = 4'd0;
        en_d        = '0;
        flag_d      = '0;
        code_flat_d = '0;
        st_flat_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            code_d[i]   = code_q[i];
            retry_d[i]  = retry_q[i];
            stable_d[i] = '0;
            fault_hit   = 1'b0;
            fault_kind  = 4'd0;
            retry_inc   = 4'd0;
            case (state_q[i])
                ST_IDLE: begin
                    if (battery_connected[i] && !battery_full[i])
                        state_d[i] = ST_CHECK;
                end
                ST_CHECK: begin
                    if (grid_crit) begin
                        fault_hit = 1'b1; fault_kind = 4'd1;
                    end else if (grid_inv) begin
                        fault_hit = 1'b1; fault_kind = 4'd2;
                    end else if (!battery_connected[i])
                        state_d[i] = ST_IDLE;
                    else if (grid_unstable || ml_predict_instability)
                        state_d[i] = ST_WAIT;
                    else if (grant[i])
                        state_d[i] = ST_CHARGING;
                end
                ST_WAIT: begin
                    if (grid_crit) begin
                        fault_hit = 1'b1; fault_kind = 4'd1;
                    end else if (grid_inv) begin
                        fault_hit = 1'b1; fault_kind = 4'd2;
                    end else if (!battery_connected[i])
                        state_d[i] = ST_IDLE;
                    else if (clean) begin
                        if (stable_q[i] == WW'(WAIT_CYCLES - 1))
                            state_d[i] = ST_CHECK;
                        else
                            stable_d[i] = stable_q[i] + 1'b1;
                    end
                end
                ST_CHARGING: begin
                    if (grid_crit) begin
                        fault_hit = 1'b1; fault_kind = 4'd1;
                    end else if (grid_inv) begin
                        fault_hit = 1'b1; fault_kind = 4'd2;
                    end else if (!battery_connected[i]) begin
                        fault_hit = 1'b1; fault_kind = 4'd3;
                    end else if (battery_full[i]) begin
                        state_d[i] = ST_IDLE;
                        retry_d[i] = 4'd0;
                    end else if (grid_unstable || ml_predict_instability)
                        state_d[i] = ST_WAIT;
                end
                ST_FAULT: begin
                    if (fault_clear && grid_normal) begin
                        state_d[i] = ST_IDLE;
                        code_d[i]  = 4'd0;
                    end
                end
                ST_LOCKOUT: begin
                    state_d[i] = ST_LOCKOUT;
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    code_d[i]  = 4'd0;
                end
            endcase
            if (fault_hit) begin
                retry_inc  = (retry_q[i] == 4'hF) ? 4'hF : retry_q[i] + 4'd1;
                retry_d[i] = retry_inc;
                if (retry_inc == 4'(MAX_RETRY)) begin
                    state_d[i] = ST_LOCKOUT;
                    code_d[i]  = 4'd4;
                end else begin
                    state_d[i] = ST_FAULT;
                    code_d[i]  = fault_kind;
                end
            end
            en_d[i]             = (state_d[i] == ST_CHARGING);
            flag_d[i]           = (state_d[i] == ST_FAULT) || (state_d[i] == ST_LOCKOUT);
            code_flat_d[4*i +: 4] = code_d[i];
            st_flat_d[3*i +: 3]   = state_d[i];
        end
    end

    // State, counters and outputs all register on the same edge; outputs are
    // decoded from the next state so they track the state registers exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                code_q[i]   <= 4'd0;
                retry_q[i]  <= 4'd0;
                stable_q[i] <= '0;
            end
            stagger_q     <= '0;
            charge_enable <= '0;
            fault_flag    <= '0;
            fault_code    <= '0;
            ch_state      <= '0;
            any_fault     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                code_q[i]   <= code_d[i];
                retry_q[i]  <= retry_d[i];
                stable_q[i] <= stable_d[i];
            end
            stagger_q     <= stagger_d;
            charge_enable <= en_d;
            fault_flag    <= flag_d;
            fault_code    <= code_flat_d;
            ch_state      <= st_flat_d;
            any_fault     <= |flag_d;
        end
    end

endmodule

// File: tb/tb_sc_charge_supervisor_mc.sv
// tb_sc_charge_supervisor_mc
// -----------------------------------------------------------------------------
// Directed testbench for sc_charge_supervisor_mc with default parameters
// (4 channels, WAIT_CYCLES=16, MAX_RETRY=3, STAGGER_CYCLES=8). Each scenario
// task drives its own stimulus and checks outputs with hand-computed values.
// -----------------------------------------------------------------------------
module tb_sc_charge_supervisor_mc;

    logic        clk;
    logic        reset_n;
    logic [1:0]  grid_state;
    logic        ml_predict_instability;
    logic [3:0]  battery_connected;
    logic [3:0]  battery_full;
    logic        fault_clear;
    logic [3:0]  charge_enable;
    logic [3:0]  fault_flag;
    logic [15:0] fault_code;
    logic [11:0] ch_state;
    logic        any_fault;

    int checks   = 0;
    int failures = 0;

    sc_charge_supervisor_mc #(
        .N_CH(4), .WAIT_CYCLES(16), .MAX_RETRY(3), .STAGGER_CYCLES(8)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .grid_state             (grid_state),
        .ml_predict_instability (ml_predict_instability),
        .battery_connected      (battery_connected),
        .battery_full           (battery_full),
        .fault_clear            (fault_clear),
        .charge_enable          (charge_enable),
        .fault_flag             (fault_flag),
        .fault_code             (fault_code),
        .ch_state               (ch_state),
        .any_fault              (any_fault)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with all inputs quiet, then release just after
    // an edge so the next rising edge is cycle 1.
    task automatic do_reset();
        reset_n                = 1'b0;
        grid_state             = 2'b00;
        ml_predict_instability = 1'b0;
        battery_connected      = 4'b0000;
        battery_full           = 4'b0000;
        fault_clear            = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({charge_enable, fault_flag, fault_code, ch_state, any_fault} !== 37'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got en=%b flag=%b code=%h st=%h any=%b want all 0",
                     charge_enable, fault_flag, fault_code, ch_state, any_fault);
        end
        // Bring ch0 into CHARGING, then assert reset between edges.
        do_reset();
        battery_connected = 4'b0001;
        step(2);
        checks++;
        if (charge_enable !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL pre_async_reset_en got %b want 0001", charge_enable);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (charge_enable !== 4'b0000 || ch_state !== 12'h000) begin
            failures++;
            $display("[TB] FAIL async_reset_drop got en=%b st=%h want 0000/000", charge_enable, ch_state);
        end
    endtask

    task automatic test_single_start();
        do_reset();
        battery_connected = 4'b0001;
        step(1);
        checks++;
        if (ch_state[2:0] !== 3'd1 || charge_enable !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_cycle1 got st0=%0d en=%b want 1/0000", ch_state[2:0], charge_enable);
        end
        step(1);
        checks++;
        if (charge_enable !== 4'b0001 || fault_code !== 16'h0000 || ch_state[2:0] !== 3'd3) begin
            failures++;
            $display("[TB] FAIL single_cycle2 got en=%b code=%h st0=%0d want 0001/0000/3",
                     charge_enable, fault_code, ch_state[2:0]);
        end
        battery_full = 4'b0001;
        step(1);
        checks++;
        if (charge_enable !== 4'b0000 || ch_state[2:0] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL full_to_idle got en=%b st0=%0d want 0000/0", charge_enable, ch_state[2:0]);
        end
    endtask

    task automatic test_stagger();
        logic [3:0] exp_en;
        do_reset();
        battery_connected = 4'b1111;
        for (int c = 1; c <= 28; c++) begin
            step(1);
            exp_en = 4'b0000;
            for (int j = 0; j < 4; j++)
                if (c >= 2 + 8 * j) exp_en[j] = 1'b1;
            checks++;
            if (charge_enable !== exp_en) begin
                failures++;
                $display("[TB] FAIL stagger_c%0d got en=%b want %b", c, charge_enable, exp_en);
            end
            if (c == 1) begin
                checks++;
                if (ch_state !== 12'b001_001_001_001) begin
                    failures++;
                    $display("[TB] FAIL stagger_all_check got st=%h want 249", ch_state);
                end
            end
        end
    endtask

    task automatic test_wait_hysteresis();
        do_reset();
        battery_connected = 4'b0001;
        step(2);
        grid_state = 2'b01;
        step(1);
        checks++;
        if (ch_state[2:0] !== 3'd2 || charge_enable !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL wait_entry got st0=%0d en=%b want 2/0000", ch_state[2:0], charge_enable);
        end
        grid_state = 2'b00;
        step(10);
        ml_predict_instability = 1'b1;
        step(1);
        ml_predict_instability = 1'b0;
        checks++;
        if (ch_state[2:0] !== 3'd2) begin
            failures++;
            $display("[TB] FAIL wait_ml_pulse got st0=%0d want 2", ch_state[2:0]);
        end
        step(15);
        checks++;
        if (ch_state[2:0] !== 3'd2) begin
            failures++;
            $display("[TB] FAIL wait_after15 got st0=%0d want 2", ch_state[2:0]);
        end
        step(1);
        checks++;
        if (ch_state[2:0] !== 3'd1 || charge_enable !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL wait_to_check got st0=%0d en=%b want 1/0000", ch_state[2:0], charge_enable);
        end
        step(1);
        checks++;
        if (charge_enable !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL wait_resume got en=%b want 0001", charge_enable);
        end
    endtask

    task automatic test_fault_clear();
        do_reset();
        battery_connected = 4'b0010;
        step(2);
        grid_state = 2'b10;
        step(1);
        checks++;
        if (fault_flag !== 4'b0010 || fault_code[7:4] !== 4'd1 || any_fault !== 1'b1 ||
            ch_state[5:3] !== 3'd4 || charge_enable !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL crit_fault got flag=%b code1=%0d any=%b st1=%0d en=%b want 0010/1/1/4/0000",
                     fault_flag, fault_code[7:4], any_fault, ch_state[5:3], charge_enable);
        end
        fault_clear = 1'b1;
        step(1);
        checks++;
        if (ch_state[5:3] !== 3'd4 || fault_code[7:4] !== 4'd1) begin
            failures++;
            $display("[TB] FAIL clear_in_crit got st1=%0d code1=%0d want 4/1", ch_state[5:3], fault_code[7:4]);
        end
        grid_state = 2'b00;
        step(1);
        checks++;
        if (ch_state[5:3] !== 3'd0 || fault_code !== 16'h0000 || fault_flag !== 4'b0000 || any_fault !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_normal got st1=%0d code=%h flag=%b any=%b want 0/0000/0000/0",
                     ch_state[5:3], fault_code, fault_flag, any_fault);
        end
        step(1);
        checks++;
        if (ch_state[5:3] !== 3'd1) begin
            failures++;
            $display("[TB] FAIL clear_held_recheck got st1=%0d want 1", ch_state[5:3]);
        end
        fault_clear = 1'b0;
    endtask

    task automatic test_lockout();
        do_reset();
        battery_connected = 4'b0100;
        step(1);
        grid_state = 2'b10;
        step(1);
        checks++;
        if (ch_state[8:6] !== 3'd4 || fault_code[11:8] !== 4'd1) begin
            failures++;
            $display("[TB] FAIL lock_fault1 got st2=%0d code2=%0d want 4/1", ch_state[8:6], fault_code[11:8]);
        end
        grid_state = 2'b00; fault_clear = 1'b1;
        step(1);
        fault_clear = 1'b0;
        step(1);
        grid_state = 2'b11;
        step(1);
        checks++;
        if (ch_state[8:6] !== 3'd4 || fault_code[11:8] !== 4'd2) begin
            failures++;
            $display("[TB] FAIL lock_fault2_invalid got st2=%0d code2=%0d want 4/2", ch_state[8:6], fault_code[11:8]);
        end
        grid_state = 2'b00; fault_clear = 1'b1;
        step(1);
        fault_clear = 1'b0;
        step(1);
        grid_state = 2'b10;
        step(1);
        checks++;
        if (ch_state[8:6] !== 3'd5 || fault_code[11:8] !== 4'd4 || fault_flag !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL lock_entry got st2=%0d code2=%0d flag=%b want 5/4/0100",
                     ch_state[8:6], fault_code[11:8], fault_flag);
        end
        grid_state = 2'b00; fault_clear = 1'b1;
        step(2);
        fault_clear = 1'b0;
        checks++;
        if (ch_state[8:6] !== 3'd5 || fault_code[11:8] !== 4'd4) begin
            failures++;
            $display("[TB] FAIL lock_ignores_clear got st2=%0d code2=%0d want 5/4", ch_state[8:6], fault_code[11:8]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ch_state !== 12'h000 || fault_flag !== 4'b0000 || fault_code !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL lock_reset got st=%h flag=%b code=%h want 000/0000/0000", ch_state, fault_flag, fault_code);
        end
        step(1);
        reset_n = 1'b1;
    endtask

    task automatic test_remove_full();
        do_reset();
        battery_connected = 4'b1111;
        step(26);
        checks++;
        if (charge_enable !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL remove_all_charging got en=%b want 1111", charge_enable);
        end
        battery_connected = 4'b0111;
        battery_full      = 4'b1000;
        step(1);
        checks++;
        if (ch_state[11:9] !== 3'd4 || fault_code !== 16'h3000 || charge_enable !== 4'b0111 ||
            fault_flag !== 4'b1000 || any_fault !== 1'b1) begin
            failures++;
            $display("[TB] FAIL remove_and_full got st3=%0d code=%h en=%b flag=%b any=%b want 4/3000/0111/1000/1",
                     ch_state[11:9], fault_code, charge_enable, fault_flag, any_fault);
        end
    endtask

    initial begin
        test_reset();
        test_single_start();
        test_stagger();
        test_wait_hysteresis();
        test_fault_clear();
        test_lockout();
        test_remove_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_charge_supervisor_mc.md
# sc_charge_supervisor_mc

Multi-channel successor to the single-charger supervisor. It runs one independent charge-control FSM per charger channel, parametrised in channel count. All channels share one grid-state input and one ML instability prediction. Beyond the single-channel block it adds:
- a hysteresis timer before resuming from WAIT;
- a retry counter with permanent lockout;
- a staggered-start arbiter that limits inrush on a weak grid.

## Interface
Parameters:
- N_CH, 4, number of charger channels (1..16)
- WAIT_CYCLES, 16, consecutive clean-grid cycles required to leave WAIT (>=1)
- MAX_RETRY, 3, fault entries allowed before LOCKOUT (1..15)
- STAGGER_CYCLES, 8, minimum cycles between two channel charge starts (>=1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- grid_state  in  2  00 NORMAL, 01 UNSTABLE, 10 CRITICAL, 11 invalid
- ml_predict_instability  in  1  ML forecast of imminent instability
- battery_connected  in  N_CH  per-channel battery presence
- battery_full  in  N_CH  per-channel full indication
- fault_clear  in  1  operator acknowledge; acts only while asserted
- charge_enable  out  N_CH  bit i is high iff channel i is in CHARGING
- fault_flag  out  N_CH  bit i is high iff channel i is in FAULT or LOCKOUT
- fault_code  out  4*N_CH  channel i occupies bits [4i+3:4i]
- ch_state  out  3*N_CH  per-channel state encoding, for diagnostics
- any_fault  out  1  OR of all fault_flag bits

## Operation
State encoding: IDLE=0, CHECK=1, WAIT=2, CHARGING=3, FAULT=4, LOCKOUT=5.

Fault codes:
- 0 none
- 1 grid critical
- 2 grid invalid
- 3 battery removed while charging
- 4 retry exhausted

"Clean" means grid_state==NORMAL and ml_predict_instability==0.

Per-channel transitions. In each state the first matching rule wins.
- IDLE:
  - connected and !full -> CHECK.
- CHECK:
  - CRITICAL -> FAULT(1).
  - Invalid grid -> FAULT(2).
  - !connected -> IDLE.
  - UNSTABLE or ml -> WAIT.
  - Clean and granted -> CHARGING.
  - Otherwise stay in CHECK.
- WAIT:
  - CRITICAL -> FAULT(1).
  - Invalid grid -> FAULT(2).
  - !connected -> IDLE.
  - Per-channel stable counter: increments on each clean cycle and clears to 0 on any non-clean cycle.
  - When a clean cycle occurs with the counter at WAIT_CYCLES-1 -> CHECK, and the counter clears.
- CHARGING:
  - CRITICAL -> FAULT(1).
  - Invalid grid -> FAULT(2).
  - !connected -> FAULT(3).
  - full -> IDLE, and retry_cnt clears.
  - UNSTABLE or ml -> WAIT.
  - Otherwise stay in CHARGING.
- FAULT entry:
  - retry_cnt increments (saturating, 4 bits).
  - If the incremented value equals MAX_RETRY, the channel enters LOCKOUT with code 4 instead of FAULT.
- FAULT:
  - fault_clear and grid NORMAL -> IDLE, and the code clears to 0.
  - Otherwise hold state and code.
- LOCKOUT:
  - Exits only via reset_n.
  - Ignores fault_clear.

Stagger arbiter:
- One shared down-counter, stagger_cnt.
- A grant is issued only when stagger_cnt==0.
- When granting, the arbiter picks the lowest-index channel that is in CHECK and sees a clean grid.
- At most one grant per cycle.
- On a grant, stagger_cnt loads STAGGER_CYCLES-1.
- Otherwise stagger_cnt decrements toward 0 and saturates at 0.

Grid and ML conditions are evaluated identically by all channels in the same cycle, so a CRITICAL cycle faults every active channel simultaneously. IDLE channels are unaffected by grid state.

## Timing
- Every output is a registered Moore decode of the state and code registers.
- Any input change is visible on the outputs one clk edge later.
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - all states IDLE;
  - charge_enable=0, fault_flag=0, fault_code=0, any_fault=0, ch_state=0;
  - retry_cnt=0, stable counters=0, stagger_cnt=0.
- Reset mid-charge drops charge_enable immediately (asynchronously).
- Minimum WAIT dwell:
  - WAIT_CYCLES cycles with a clean grid, then one cycle in CHECK, then CHARGING.
  - The CHECK cycle lasts longer if no grant is available.
- With k channels requesting simultaneously, channel j (ordered by index) starts j*STAGGER_CYCLES cycles after the first.
- fault_clear held high across multiple cycles clears a FAULT once. A new fault condition after IDLE re-enters normally.
- battery_full and !connected asserted together in CHARGING resolve as FAULT(3).

## Test plan
- Reset, then ch0 connected with a NORMAL grid -> cycle 1 CHECK, cycle 2 charge_enable[0]=1, fault_code all 0.
- All 4 channels connect at once with a NORMAL grid, STAGGER_CYCLES=8 -> enables rise in index order at cycles 2, 10, 18, 26.
- ch0 charging, grid UNSTABLE for 1 cycle, then NORMAL -> WAIT. One ML pulse after 10 clean cycles restarts the count. Enable returns 16 clean cycles plus 2 later.
- ch1 charging, grid=10 -> fault_flag[1]=1, code 1. fault_clear with grid CRITICAL is ignored. fault_clear with grid NORMAL -> IDLE, code 0.
- Three consecutive faults on ch2 with MAX_RETRY=3 -> third entry is LOCKOUT, code 4, ch_state=5. fault_clear is ignored. Only reset_n returns ch2 to IDLE.
- ch3 charging, battery removed in the same cycle battery_full rises -> FAULT with code 3. Other channels keep charging.
